// File: rtl/regfile.sv
// RV32I integer register file: 32 x 32-bit, two asynchronous read ports,
// one synchronous write port, x0 hardwired to zero, async active-low clear.
module regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic        [ADDR_WIDTH-1:0] read_reg1,
  input  logic        [ADDR_WIDTH-1:0] read_reg2,
  input  logic        [ADDR_WIDTH-1:0] write_reg,
  input  logic signed [DATA_WIDTH-1:0] write_data,
  input  logic                         write_en,
  output logic signed [DATA_WIDTH-1:0] read_data1,
  output logic signed [DATA_WIDTH-1:0] read_data2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [DEPTH];
  logic                  w_wr_commit;

  // Writes to x0 are dropped here so r_regs[0] stays at its reset value.
  assign w_wr_commit = write_en && (write_reg != {ADDR_WIDTH{1'b0}});

  // Register storage: asynchronous clear, write on rising edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (w_wr_commit) begin
      r_regs[write_reg] <= write_data;
    end
  end

  // Read port 1: no write bypass; x0 forced to zero.
  always_comb begin
    read_data1 = {DATA_WIDTH{1'b0}};
    if (read_reg1 != {ADDR_WIDTH{1'b0}}) begin
      read_data1 = r_regs[read_reg1];
    end else begin
      read_data1 = {DATA_WIDTH{1'b0}};
    end
  end

  // Read port 2: no write bypass; x0 forced to zero.
  always_comb begin
    read_data2 = {DATA_WIDTH{1'b0}};
    if (read_reg2 != {ADDR_WIDTH{1'b0}}) begin
      read_data2 = r_regs[read_reg2];
    end else begin
      read_data2 = {DATA_WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: stimulus queues expected read values,
// a monitor process pops and compares them on each check strobe.
module tb_regfile;

  logic               clk;
  logic               rstn;
  logic        [4:0]  read_reg1;
  logic        [4:0]  read_reg2;
  logic        [4:0]  write_reg;
  logic signed [31:0] write_data;
  logic               write_en;
  logic signed [31:0] read_data1;
  logic signed [31:0] read_data2;

  logic               chk_strobe;
  logic        [31:0] q_exp1 [$];
  logic        [31:0] q_exp2 [$];
  string              q_tag  [$];
  int                 checks;
  int                 errors;

  regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .write_reg  (write_reg),
    .write_data (write_data),
    .write_en   (write_en),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: on each strobe, pop one expectation and compare both ports.
  always @(posedge chk_strobe) begin
    logic [31:0] e1, e2;
    string       tag;
    if (q_tag.size() == 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL scoreboard_empty: strobe with no expectation queued");
    end else begin
      e1  = q_exp1.pop_front();
      e2  = q_exp2.pop_front();
      tag = q_tag.pop_front();
      checks = checks + 1;
      if (read_data1 !== e1 || read_data2 !== e2) begin
        errors = errors + 1;
        $display("FAIL %s: got rd1=%h rd2=%h, expected rd1=%h rd2=%h",
                 tag, read_data1, read_data2, e1, e2);
      end
    end
  end

  task automatic expect_read(input logic [4:0] a1, input logic [4:0] a2,
                             input logic [31:0] e1, input logic [31:0] e2,
                             input string tag);
    q_exp1.push_back(e1);
    q_exp2.push_back(e2);
    q_tag.push_back(tag);
    read_reg1 = a1;
    read_reg2 = a2;
    #1 chk_strobe = 1'b1;
    #1 chk_strobe = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] rd, input logic [31:0] val);
    @(negedge clk);
    write_reg  = rd;
    write_data = val;
    write_en   = 1'b1;
    @(negedge clk);
    write_en   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks     = 0;
    errors     = 0;
    chk_strobe = 1'b0;
    rstn       = 1'b0;
    read_reg1  = 5'd0;
    read_reg2  = 5'd0;
    write_reg  = 5'd0;
    write_data = 32'sd0;
    write_en   = 1'b0;

    expect_read(5'd10, 5'd30, 32'd0, 32'd0, "reset_initial");
    @(negedge clk);
    rstn = 1'b1;

    do_write(5'd10, 32'd12983);
    do_write(5'd30, 32'd324);
    expect_read(5'd10, 5'd30, 32'd12983, 32'd324, "basic_write");

    @(negedge clk);
    write_reg  = 5'd10;
    write_data = 32'sd500;
    write_en   = 1'b0;
    @(negedge clk);
    expect_read(5'd10, 5'd30, 32'd12983, 32'd324, "enable_low");

    do_write(5'd0, 32'd500);
    expect_read(5'd10, 5'd0, 32'd12983, 32'd0, "x0_hardwired");
    expect_read(5'd0, 5'd0, 32'd0, 32'd0, "x0_both_ports");

    // Read-during-write: old value before the edge, new value after it.
    @(negedge clk);
    write_reg  = 5'd5;
    write_data = 32'hDEADBEEF;
    write_en   = 1'b1;
    expect_read(5'd5, 5'd5, 32'd0, 32'd0, "rdw_before_edge");
    @(posedge clk);
    #1;
    expect_read(5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, "rdw_after_edge");
    @(negedge clk);
    write_en = 1'b0;

    do_write(5'd31, -32'sd1);
    expect_read(5'd31, 5'd10, 32'hFFFFFFFF, 32'd12983, "negative_x31");

    // Write data changing between edges with enable low must not land.
    @(negedge clk);
    write_reg  = 5'd31;
    write_data = 32'sd77;
    #2 write_data = 32'sd88;
    @(negedge clk);
    expect_read(5'd31, 5'd5, 32'hFFFFFFFF, 32'hDEADBEEF, "no_write_between_edges");

    // Async reset mid-operation, with a write attempted during reset.
    @(negedge clk);
    rstn       = 1'b0;
    write_reg  = 5'd7;
    write_data = 32'sd4660;
    write_en   = 1'b1;
    expect_read(5'd10, 5'd30, 32'd0, 32'd0, "reset_async_clear");
    expect_read(5'd31, 5'd5, 32'd0, 32'd0, "reset_async_clear2");
    @(posedge clk);
    #1;
    @(negedge clk);
    rstn     = 1'b1;
    write_en = 1'b0;
    expect_read(5'd7, 5'd10, 32'd0, 32'd0, "write_lost_in_reset");

    do_write(5'd7, 32'd99);
    expect_read(5'd7, 5'd0, 32'd99, 32'd0, "first_write_after_reset");

    for (int i = 1; i < 32; i++) begin
      do_write(i[4:0], i + 1);
    end
    for (int i = 0; i < 32; i++) begin
      logic [31:0] e1, e2;
      e1 = (i == 0) ? 32'd0 : 32'(i + 1);
      e2 = (i == 31) ? 32'd0 : 32'(32 - i);
      expect_read(i[4:0], 5'(31 - i), e1, e2, "sweep_pair");
    end

    #5;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
